onchip_mem_copy_master: RTL and testbench

Avalon-MM initiator that drives the on-chip memory slave port with block fill and block copy operations. It accepts one command at a time and issues single-word, non-pipelined read/write transfers honouring `waitrequest` and a fixed read latency. It sits between the controller logic and the 16-bit, 14-bit word-addressed on-chip RAM, and is used to clear the RAM, load patterns into it, and relocate tables within it without CPU involvement.

---
 rtl/onchip_mem_copy_master.sv | 168 ++++++++++++++++
 tb/tb_onchip_mem_copy_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM initiator performing block fill and forward block copy on the on-chip RAM.
// One command at a time; single-word, non-pipelined transfers with fixed read latency.
module onchip_mem_copy_master #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned BE_W         = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_fill,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_read,
    output logic              m_write,
    output logic [BE_W-1:0]   m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned LAT_W = 2;

    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_LAT, ST_WR, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                fill_q, fill_d;
    logic [DATA_W-1:0]   pat_q, pat_d, data_q, data_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                cs_q, cs_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // State, datapath and registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            fill_q      <= 1'b0;
            pat_q       <= '0;
            data_q      <= '0;
            lat_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            pat_q       <= pat_d;
            data_q      <= data_d;
            lat_q       <= lat_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        data_d  = data_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d  = cmd_src;
                    dst_d  = cmd_dst;
                    rem_d  = cmd_len;
                    fill_d = cmd_fill;
                    pat_d  = cmd_pattern;
                    if (cmd_len == '0)  state_d = ST_DONE;
                    else if (cmd_fill)  state_d = ST_WR;
                    else                state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (!m_waitrequest) begin
                    state_d = ST_LAT;
                    lat_d   = LAT_W'(READ_LATENCY);
                end
            end
            ST_LAT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    data_d  = m_readdata;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (!m_waitrequest) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                    else if (fill_q)        state_d = ST_WR;
                    else                    state_d = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they are registered with it
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        rd_d        = (state_d == ST_RD);
        wr_d        = (state_d == ST_WR);
        cs_d        = rd_d | wr_d;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if (rd_d) begin
            addr_d = src_d;
        end else if (wr_d) begin
            addr_d  = dst_d;
            wdata_d = fill_d ? pat_d : data_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign m_read       = rd_q;
    assign m_write      = wr_q;
    assign m_chipselect = cs_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign m_byteenable = '1;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master with a RAM model and programmable waitrequest stalls.
module tb_onchip_mem_copy_master;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_fill = 1'b0;
    logic [ADDR_W-1:0] cmd_src = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic [DATA_W-1:0] cmd_pattern = '0;
    logic              busy, done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect, m_read, m_write;
    logic [BE_W-1:0]   m_byteenable;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;

    onchip_mem_copy_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fill(cmd_fill),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
        .busy(busy), .done(done),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    // RAM model: read data valid one cycle after acceptance
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_pipe = '0;
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    int                rd_stall = 0;
    int                wr_stall = 0;

    assign m_waitrequest = (m_read && rd_stall > 0) || (m_write && wr_stall > 0);
    assign m_readdata    = rd_pipe;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (m_write && !m_waitrequest) mem[m_address] <= m_writedata;
        if (m_read && !m_waitrequest) rd_pipe <= mem[m_address];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    int                wr_cyc[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];

    // Issue one command and watch it until done; inject > 0 presents a stray command that cycle
    task automatic run_cmd(input logic fill, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input logic [ADDR_W:0] len, input logic [DATA_W-1:0] pat, input int inject,
                           output int done_cyc, output int n_rd, output bit stable_ok, output bit excl_ok);
        bit prev_stall, prev_rs, prev_ws, prev_rd, prev_wr;
        logic [ADDR_W-1:0] prev_addr;
        logic [DATA_W-1:0] prev_wd;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_cyc = -1; n_rd = 0; stable_ok = 1'b1; excl_ok = 1'b1;
        prev_stall = 1'b0; prev_rs = 1'b0; prev_ws = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
        prev_addr = '0; prev_wd = '0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_fill = fill; cmd_src = src; cmd_dst = dst;
        cmd_len = len; cmd_pattern = pat;
        for (int n = 1; n <= 300 && done_cyc < 0; n++) begin
            @(posedge clk);
            #1;
            if (prev_rs) rd_stall--;
            if (prev_ws) wr_stall--;
            @(negedge clk);
            if (n == inject) begin
                cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_dst = 14'h0200;
                cmd_len = 15'd2; cmd_pattern = 16'hDEAD;
            end else begin
                cmd_valid = 1'b0;
            end
            if (m_read && m_write) excl_ok = 1'b0;
            if (prev_stall && (m_address !== prev_addr || m_read !== prev_rd ||
                               m_write !== prev_wr || (m_write && m_writedata !== prev_wd)))
                stable_ok = 1'b0;
            prev_stall = m_waitrequest;
            prev_rs    = m_read && m_waitrequest;
            prev_ws    = m_write && m_waitrequest;
            prev_rd    = m_read;
            prev_wr    = m_write;
            prev_addr  = m_address;
            prev_wd    = m_writedata;
            if (m_read && !m_waitrequest) n_rd++;
            if (m_write && !m_waitrequest) begin
                wr_cyc.push_back(n); wr_addr.push_back(m_address); wr_data.push_back(m_writedata);
            end
            if (done) done_cyc = n;
        end
        cmd_valid = 1'b0;
    endtask

    int dc, nrd, seen_done;
    bit st_ok, ex_ok;
    logic [ADDR_W-1:0] exp_a [4];

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", {29'd0, m_read, m_write, m_chipselect}, 32'd0);
        check("rst_address", 32'(m_address), 32'd0);
        check("rst_writedata", 32'(m_writedata), 32'd0);
        check("rst_byteenable", 32'(m_byteenable), 32'h3);
        reset_n = 1'b1;

        // Fill 0x10..0x13 with A5A5
        run_cmd(1'b1, 14'h0000, 14'h0010, 15'd4, 16'hA5A5, 0, dc, nrd, st_ok, ex_ok);
        check("fill_done_cycle", 32'(dc), 32'd5);
        check("fill_nwrites", 32'(wr_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            check("fill_wr_cycle", 32'(wr_cyc[i]), 32'(i + 1));
            check("fill_wr_addr", 32'(wr_addr[i]), 32'h10 + 32'(i));
            check("fill_wr_data", 32'(wr_data[i]), 32'hA5A5);
        end
        check("fill_no_reads", 32'(nrd), 32'd0);
        @(negedge clk);
        check("fill_ready_after_done", {30'd0, cmd_ready, done}, 32'h2);

        // Copy 0x0000..0x0002 to 0x0100
        preload(14'h0000, 16'h1111);
        preload(14'h0001, 16'h2222);
        preload(14'h0002, 16'h3333);
        run_cmd(1'b0, 14'h0000, 14'h0100, 15'd3, 16'h0000, 0, dc, nrd, st_ok, ex_ok);
        check("copy_done_cycle", 32'(dc), 32'd10);
        check("copy_nreads", 32'(nrd), 32'd3);
        check("copy_mem_100", 32'(mem[14'h0100]), 32'h1111);
        check("copy_mem_101", 32'(mem[14'h0101]), 32'h2222);
        check("copy_mem_102", 32'(mem[14'h0102]), 32'h3333);
        if (wr_cyc.size() == 3) check("copy_wr3_cycle", 32'(wr_cyc[2]), 32'd9);
        else check("copy_nwrites", 32'(wr_cyc.size()), 32'd3);
        check("copy_exclusive", 32'(ex_ok), 32'd1);

        // Copy with 3 stall cycles on first read and 2 on first write
        preload(14'h0020, 16'hAAAA);
        preload(14'h0021, 16'hBBBB);
        preload(14'h0022, 16'hCCCC);
        rd_stall = 3; wr_stall = 2;
        run_cmd(1'b0, 14'h0020, 14'h0300, 15'd3, 16'h0000, 0, dc, nrd, st_ok, ex_ok);
        check("stall_done_cycle", 32'(dc), 32'd15);
        check("stall_stable", 32'(st_ok), 32'd1);
        check("stall_mem_300", 32'(mem[14'h0300]), 32'hAAAA);
        check("stall_mem_302", 32'(mem[14'h0302]), 32'hCCCC);
        check("stall_exclusive", 32'(ex_ok), 32'd1);

        // Address wrap-around
        exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
        run_cmd(1'b1, 14'h0000, 14'h3FFE, 15'd4, 16'h5A5A, 0, dc, nrd, st_ok, ex_ok);
        check("wrap_done_cycle", 32'(dc), 32'd5);
        check("wrap_nwrites", 32'(wr_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++)
            check("wrap_wr_addr", 32'(wr_addr[i]), 32'(exp_a[i]));
        check("wrap_mem_0001", 32'(mem[14'h0001]), 32'h5A5A);

        // Zero length
        run_cmd(1'b1, 14'h0000, 14'h0400, 15'd0, 16'hFFFF, 0, dc, nrd, st_ok, ex_ok);
        check("zero_done_cycle", 32'(dc), 32'd1);
        check("zero_no_bus", 32'(wr_cyc.size() + nrd), 32'd0);

        // Stray command while busy is ignored
        preload(14'h0200, 16'h0BAD);
        preload(14'h0201, 16'h0BAD);
        run_cmd(1'b1, 14'h0000, 14'h0500, 15'd3, 16'h1234, 2, dc, nrd, st_ok, ex_ok);
        check("busy_done_cycle", 32'(dc), 32'd4);
        check("busy_nwrites", 32'(wr_cyc.size()), 32'd3);
        check("busy_mem_502", 32'(mem[14'h0502]), 32'h1234);
        repeat (3) @(negedge clk);
        check("busy_stray_ignored", {mem[14'h0200], mem[14'h0201]}, 32'h0BAD0BAD);
        check("busy_idle_after", {30'd0, busy, m_write}, 32'd0);

        // Reset during word 3 read of a 5-word copy
        for (int i = 0; i < 5; i++) preload(14'h0040 + 14'(i), 16'h7000 + 16'(i));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_src = 14'h0040; cmd_dst = 14'h0600;
        cmd_len = 15'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rstmid_reading", {30'd0, m_read, busy}, 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_strobes", {29'd0, m_read, m_write, m_chipselect}, 32'd0);
        check("rstmid_busy_ready", {30'd0, busy, cmd_ready}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("rstmid_no_done", 32'(seen_done), 32'd0);
        check("rstmid_word3_unwritten", 32'(mem[14'h0602] === 16'h7002), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
